// File: rtl/matmul_apb_arbiter.sv
// ---------------------------------------------------------------------------
// matmul_apb_arbiter
//
// Purpose:
//   Round-robin arbiter that shares the matmul accelerator's single APB slave
//   port between NUM_REQ requesters. One request is accepted per grant. The
//   arbiter then runs the APB SETUP/ACCESS sequence, honouring pready wait
//   states. The read data and slave error go back to the granted requester.
//   Writes are held off while the accelerator reports busy. This keeps
//   operand and control registers stable during a computation.
//
// Configuration macro:
//   MATMUL_ARB_TIMEOUT_EN - when defined, an ACCESS phase that waits
//   TIMEOUT_CYCLES cycles without pready is aborted with an error response.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i         per-requester request valid (held until accepted)
//   req_write_i         per-requester direction, 1 = write
//   req_addr_i          packed addresses, requester k at slice k
//   req_wdata_i         packed write data
//   req_strb_i          packed byte strobes
//   req_ready_o         one-hot acceptance pulse
//   rsp_valid_o         one-hot, one-cycle completion pulse
//   rsp_rdata_o         read data (0 for writes), valid with rsp_valid_o
//   rsp_err_o           slave error, valid with rsp_valid_o
//   paddr_o .. pstrb_o  APB master outputs (registered)
//   prdata_i, pready_i, pslverr_i  APB slave responses
//   busy_i              accelerator busy flag
// ---------------------------------------------------------------------------
module matmul_apb_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ-1:0]              req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]    req_wdata_i,
    input  logic [NUM_REQ*BUS_WIDTH/8-1:0]  req_strb_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    output logic [BUS_WIDTH-1:0]            rsp_rdata_o,
    output logic                            rsp_err_o,
    output logic [ADDR_WIDTH-1:0]           paddr_o,
    output logic                            psel_o,
    output logic                            penable_o,
    output logic                            pwrite_o,
    output logic [BUS_WIDTH-1:0]            pwdata_o,
    output logic [BUS_WIDTH/8-1:0]          pstrb_o,
    input  logic [BUS_WIDTH-1:0]            prdata_i,
    input  logic                            pready_i,
    input  logic                            pslverr_i,
    input  logic                            busy_i
);

    localparam int STRB_WIDTH = BUS_WIDTH / 8;
    localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject configurations the arbiter was not designed for at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("matmul_apb_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      eligible;
    logic                    anyEligible;
    logic                    accept;
    logic                    complete;
    logic                    abort;
    logic [IDX_WIDTH-1:0]    grantIdx;
    logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]    grant_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [BUS_WIDTH-1:0]    pwdata_q;
    logic [STRB_WIDTH-1:0]   pstrb_q;
    logic                    pwrite_q;
    logic                    psel_q;
    logic                    penable_q;
    logic [BUS_WIDTH-1:0]    rdata_q;
    logic                    err_q;

    // A read is always eligible. A write waits until the accelerator is idle.
    // The grant goes to the lowest eligible index at or above the pointer.
    // If there is none, it wraps to the lowest eligible index overall. Each
    // loop runs high-to-low, so the lowest matching index is written last.
    always_comb begin
        eligible    = req_valid_i & ~(req_write_i & {NUM_REQ{busy_i}});
        anyEligible = |eligible;
        grantIdx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                grantIdx = IDX_WIDTH'(k);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[k] && k >= int'(ptr_q)) begin
                grantIdx = IDX_WIDTH'(k);
            end
        end
        ptr_d  = (grantIdx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
        accept = (state_q == IDLE) && anyEligible && !rst_i;
    end

`ifdef MATMUL_ARB_TIMEOUT_EN
    localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_WIDTH-1:0] tmoCnt_q;

    // Counts ACCESS cycles that end without pready. The counter clears while
    // in SETUP, so every transfer starts ACCESS with a count of zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmoCnt_q <= '0;
        end else if (state_q == SETUP) begin
            tmoCnt_q <= '0;
        end else if (state_q == ACCESS && !pready_i && !abort) begin
            tmoCnt_q <= tmoCnt_q + 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. With the timeout enabled, the abort check comes
    // before pready, so a pready in the abort cycle has no effect.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE:   if (anyEligible) state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
`ifdef MATMUL_ARB_TIMEOUT_EN
                if (tmoCnt_q == TMO_WIDTH'(TIMEOUT_CYCLES)) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end else if (pready_i) begin
                    complete = 1'b1;
                    state_d  = RESP;
                end
`else
                if (pready_i) begin
                    complete = 1'b1;
                    state_d  = RESP;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. The response fields are forced to zero outside RESP,
    // so requesters only ever see data together with rsp_valid_o.
    always_comb begin
        req_ready_o = accept ? (NUM_REQ'(1) << grantIdx) : '0;
        rsp_valid_o = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
        rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
        rsp_err_o   = (state_q == RESP) && err_q;
        paddr_o     = paddr_q;
        psel_o      = psel_q;
        penable_o   = penable_q;
        pwrite_o    = pwrite_q;
        pwdata_o    = pwdata_q;
        pstrb_o     = pstrb_q;
    end

    // Datapath. Request fields are latched on acceptance and held until the
    // next grant. psel/penable are registered from the next state, so they
    // line up with SETUP and ACCESS without combinational glitches. Reads
    // drive zero write data and strobes onto the bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            grant_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                grant_q  <= grantIdx;
                ptr_q    <= ptr_d;
                paddr_q  <= req_addr_i[grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
                pwrite_q <= req_write_i[grantIdx];
                pwdata_q <= req_write_i[grantIdx] ?
                            req_wdata_i[grantIdx*BUS_WIDTH +: BUS_WIDTH] : '0;
                pstrb_q  <= req_write_i[grantIdx] ?
                            req_strb_i[grantIdx*STRB_WIDTH +: STRB_WIDTH] : '0;
            end
            psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q <= (state_d == ACCESS);
            if (complete) begin
                rdata_q <= pwrite_q ? '0 : prdata_i;
                err_q   <= pslverr_i;
            end else if (abort) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matmul_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_matmul_apb_arbiter
//
// Directed testbench for matmul_apb_arbiter with NUM_REQ=2 and 32-bit
// address and data. When a grant is expected, the stimulus pushes the
// expected response into a queue. A separate monitor pops the queue and
// compares it whenever rsp_valid_o is raised. Unless a test fixes a value,
// the APB slave model returns paddr_o ^ 0xA5A5_0000 as read data.
// ---------------------------------------------------------------------------
module tb_matmul_apb_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int BW   = 32;
    localparam int SW   = BW / 8;

    typedef struct packed {
        logic [NREQ-1:0] oneHot;
        logic [BW-1:0]   rdata;
        logic            err;
    } rsp_t;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic [NREQ-1:0]     req_valid_i = '0;
    logic [NREQ-1:0]     req_write_i = '0;
    logic [NREQ*AW-1:0]  req_addr_i  = '0;
    logic [NREQ*BW-1:0]  req_wdata_i = '0;
    logic [NREQ*SW-1:0]  req_strb_i  = '0;
    logic [NREQ-1:0]     req_ready_o;
    logic [NREQ-1:0]     rsp_valid_o;
    logic [BW-1:0]       rsp_rdata_o;
    logic                rsp_err_o;
    logic [AW-1:0]       paddr_o;
    logic                psel_o;
    logic                penable_o;
    logic                pwrite_o;
    logic [BW-1:0]       pwdata_o;
    logic [SW-1:0]       pstrb_o;
    logic [BW-1:0]       prdata_i;
    logic                pready_i  = 1'b1;
    logic                pslverr_i = 1'b0;
    logic                busy_i    = 1'b0;

    logic                useFixed   = 1'b0;
    logic [BW-1:0]       fixedRdata = '0;

    rsp_t                expQ[$];
    rsp_t                monExp;
    int                  checkCount = 0;
    int                  passCount  = 0;
    int                  cycleCnt   = 0;

    matmul_apb_arbiter #(
        .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_strb_i(req_strb_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .paddr_o(paddr_o), .psel_o(psel_o),
        .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .pstrb_o(pstrb_o), .prdata_i(prdata_i), .pready_i(pready_i),
        .pslverr_i(pslverr_i), .busy_i(busy_i)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Free-running cycle counter, used to measure grant spacing.
    always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

    // APB slave read data. A fixed value is used when a test needs an exact
    // constant; otherwise the data is derived from the address.
    always_comb prdata_i = useFixed ? fixedRdata : (paddr_o ^ 32'hA5A5_0000);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Response monitor. Each pulse on rsp_valid_o must match the oldest
    // expected response. A pulse with nothing outstanding is an error.
    always @(negedge clk_i) begin
        if (rsp_valid_o != '0) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL rsp_unexpected: got rsp_valid_o=%b, required no response",
                         rsp_valid_o);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(monExp.oneHot));
                checkOutput("rsp_rdata", rsp_rdata_o, monExp.rdata);
                checkOutput("rsp_err", 32'(rsp_err_o), 32'(monExp.err));
            end
        end
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at 100000 ns, required earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int k, input logic wr, input logic [AW-1:0] addr,
                                 input logic [BW-1:0] wdata, input logic [SW-1:0] strb);
        req_valid_i[k]             = 1'b1;
        req_write_i[k]             = wr;
        req_addr_i[k*AW +: AW]     = addr;
        req_wdata_i[k*BW +: BW]    = wdata;
        req_strb_i[k*SW +: SW]     = strb;
    endtask

    task automatic dropReq(input int k);
        req_valid_i[k] = 1'b0;
    endtask

    // Wait, with a bound, for an acceptance pulse and check which requester
    // got it. Optionally queue the response the monitor should see. The task
    // returns at the negedge of the acceptance cycle.
    task automatic waitReady(input string name, input logic [NREQ-1:0] expReady,
                             input logic [BW-1:0] expRdata, input logic expErr,
                             input bit push, output int acceptCycle);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_i);
            if (req_ready_o != '0) seen = 1'b1;
        end
        acceptCycle = cycleCnt;
        if (!seen) begin
            checkCount++;
            $display("[TB] FAIL %s: no req_ready_o within 20 cycles, required %b", name, expReady);
        end else begin
            checkOutput(name, 32'(req_ready_o), 32'(expReady));
            if (push) expQ.push_back('{oneHot: expReady, rdata: expRdata, err: expErr});
        end
    endtask

    // Wait, with a bound, for every queued response to be delivered.
    task automatic drain(input string name);
        for (int n = 0; n < 12 && expQ.size() != 0; n++) @(negedge clk_i);
        checkOutput(name, 32'(expQ.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_psel", 32'(psel_o), 32'd0);
        checkOutput("rst_penable", 32'(penable_o), 32'd0);
        checkOutput("rst_paddr", paddr_o, 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int c0, c1, c2, c3, accessCnt;

        // Single zero-wait read from requester 0.
        doReset();
        useFixed   = 1'b1;
        fixedRdata = 32'hDEAD_BEEF;
        pready_i   = 1'b1;
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0);
        waitReady("t1_ready", 2'b01, 32'hDEAD_BEEF, 1'b0, 1'b1, c0);
        @(posedge clk_i); #1; dropReq(0);
        @(negedge clk_i);
        checkOutput("t1_setup_psel", 32'(psel_o), 32'd1);
        checkOutput("t1_setup_penable", 32'(penable_o), 32'd0);
        checkOutput("t1_setup_paddr", paddr_o, 32'h10);
        checkOutput("t1_setup_pwrite", 32'(pwrite_o), 32'd0);
        @(negedge clk_i);
        checkOutput("t1_access_penable", 32'(penable_o), 32'd1);
        @(negedge clk_i);
        checkOutput("t1_c3_rsp_valid", 32'(rsp_valid_o), 32'h1);
        checkOutput("t1_c3_psel", 32'(psel_o), 32'd0);
        drain("t1_drain");
        useFixed = 1'b0;

        // Two readers that stay valid: grants alternate 0,1,0,1, with one
        // transfer every 4 cycles. The second grant also wraps the pointer.
        doReset();
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 32'h24, 32'h0, 4'h0);
        waitReady("t2_grant0", 2'b01, 32'hA5A5_0020, 1'b0, 1'b1, c0);
        waitReady("t2_grant1", 2'b10, 32'hA5A5_0024, 1'b0, 1'b1, c1);
        waitReady("t2_grant2", 2'b01, 32'hA5A5_0020, 1'b0, 1'b1, c2);
        waitReady("t2_grant3", 2'b10, 32'hA5A5_0024, 1'b0, 1'b1, c3);
        checkOutput("t2_spacing01", 32'(c1 - c0), 32'd4);
        checkOutput("t2_spacing12", 32'(c2 - c1), 32'd4);
        checkOutput("t2_spacing23", 32'(c3 - c2), 32'd4);
        @(posedge clk_i); #1; dropReq(0); dropReq(1);
        drain("t2_drain");

        // A write stalls while busy and the read goes first. When busy
        // drops, the write is issued.
        doReset();
        busy_i = 1'b1;
        applyStimulus(0, 1'b1, 32'h04, 32'h5, 4'hF);
        applyStimulus(1, 1'b0, 32'h08, 32'h0, 4'h0);
        waitReady("t3_read_first", 2'b10, 32'hA5A5_0008, 1'b0, 1'b1, c0);
        @(posedge clk_i); #1; dropReq(1);
        c1 = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_i);
            if (req_ready_o != '0) c1++;
        end
        checkOutput("t3_write_stalled", 32'(c1), 32'd0);
        @(posedge clk_i); #1; busy_i = 1'b0;
        waitReady("t3_write_grant", 2'b01, 32'h0, 1'b0, 1'b1, c0);
        @(posedge clk_i); #1; dropReq(0);
        @(negedge clk_i);
        checkOutput("t3_pwdata", pwdata_o, 32'h5);
        checkOutput("t3_pstrb", 32'(pstrb_o), 32'hF);
        checkOutput("t3_pwrite", 32'(pwrite_o), 32'd1);
        checkOutput("t3_paddr", paddr_o, 32'h04);
        drain("t3_drain");

        // A write with 3 wait states, completed with pslverr: ACCESS lasts
        // 4 cycles and the response has err=1 and rdata=0.
        pready_i  = 1'b0;
        pslverr_i = 1'b1;
        applyStimulus(0, 1'b1, 32'h0C, 32'h1234, 4'h3);
        waitReady("t4_ready", 2'b01, 32'h0, 1'b1, 1'b1, c0);
        @(posedge clk_i); #1; dropReq(0);
        @(negedge clk_i);
        checkOutput("t4_setup_penable", 32'(penable_o), 32'd0);
        accessCnt = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_i);
            if (psel_o && penable_o) accessCnt++;
        end
        @(posedge clk_i); #1; pready_i = 1'b1;
        @(negedge clk_i);
        if (psel_o && penable_o) accessCnt++;
        checkOutput("t4_pwdata_held", pwdata_o, 32'h1234);
        @(posedge clk_i); #1; pslverr_i = 1'b0;
        @(negedge clk_i);
        checkOutput("t4_access_cycles", 32'(accessCnt), 32'd4);
        checkOutput("t4_psel_dropped", 32'(psel_o), 32'd0);
        drain("t4_drain");

        // pslverr during wait states is ignored; only the value sampled
        // with pready counts.
        pready_i  = 1'b0;
        pslverr_i = 1'b1;
        applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'h0);
        waitReady("t4b_ready", 2'b10, 32'hA5A5_0014, 1'b0, 1'b1, c0);
        @(posedge clk_i); #1; dropReq(1);
        @(posedge clk_i); @(posedge clk_i); @(posedge clk_i);
        #1; pready_i = 1'b1; pslverr_i = 1'b0;
        drain("t4b_drain");

        // Reset during ACCESS: the bus goes idle, no response is produced,
        // and the pointer restarts at 0.
        pready_i = 1'b0;
        applyStimulus(0, 1'b0, 32'h2C, 32'h0, 4'h0);
        waitReady("t5_ready", 2'b01, 32'h0, 1'b0, 1'b0, c0);
        @(posedge clk_i); #1; dropReq(0);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("t5_in_access", 32'(penable_o), 32'd1);
        @(posedge clk_i); #1; rst_i = 1'b1;
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("t5_psel_after_rst", 32'(psel_o), 32'd0);
        checkOutput("t5_penable_after_rst", 32'(penable_o), 32'd0);
        checkOutput("t5_no_rsp", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i); #1;
        pready_i = 1'b1;
        applyStimulus(0, 1'b0, 32'h30, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 32'h34, 32'h0, 4'h0);
        waitReady("t5_ptr_zero", 2'b01, 32'hA5A5_0030, 1'b0, 1'b1, c0);
        @(posedge clk_i); #1; dropReq(0);
        waitReady("t5_next", 2'b10, 32'hA5A5_0034, 1'b0, 1'b1, c0);
        @(posedge clk_i); #1; dropReq(1);
        drain("t5_drain");

`ifdef MATMUL_ARB_TIMEOUT_EN
        // With pready stuck low, ACCESS runs for 16 waiting cycles plus the
        // abort cycle. The transfer then returns an error, and the next
        // request proceeds normally.
        doReset();
        pready_i = 1'b0;
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0);
        waitReady("to_ready", 2'b01, 32'h0, 1'b1, 1'b1, c0);
        @(posedge clk_i); #1; dropReq(0);
        accessCnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (penable_o) accessCnt++;
            else if (!psel_o) break;
        end
        checkOutput("to_access_cycles", 32'(accessCnt), 32'd17);
        @(posedge clk_i); #1; pready_i = 1'b1;
        applyStimulus(1, 1'b0, 32'h44, 32'h0, 4'h0);
        waitReady("to_next", 2'b10, 32'hA5A5_0044, 1'b0, 1'b1, c0);
        @(posedge clk_i); #1; dropReq(1);
        drain("to_drain");
`endif

        repeat (2) @(posedge clk_i);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/matmul_apb_arbiter.md
Name: matmul_apb_arbiter

Overview:
- Round-robin APB master arbiter: shares the single APB slave port of the matmul accelerator between NUM_REQ requesters (testbench stimulus agents, host CPU shim, DMA).
- Accepts one transfer request per grant and runs the APB SETUP/ACCESS sequence, including pready wait states.
- Returns prdata/pslverr to the granted requester.
- Gates writes while the accelerator reports busy, so operand/control registers are not disturbed mid-computation.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 32, APB address width
BUS_WIDTH, 32, APB data width; pstrb width is BUS_WIDTH/8
TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  NUM_REQ  per-requester request valid; held until accepted
req_write_i  in  NUM_REQ  per-requester: 1 write, 0 read
req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at slice k
req_wdata_i  in  NUM_REQ*BUS_WIDTH  packed write data
req_strb_i  in  NUM_REQ*BUS_WIDTH/8  packed byte strobes
req_ready_o  out  NUM_REQ  one-hot acceptance pulse
rsp_valid_o  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata_o  out  BUS_WIDTH  read data; valid with rsp_valid_o, 0 for writes
rsp_err_o  out  1  slave error; valid with rsp_valid_o
paddr_o  out  ADDR_WIDTH  APB address
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  BUS_WIDTH  APB write data
pstrb_o  out  BUS_WIDTH/8  APB strobes
prdata_i  in  BUS_WIDTH  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error
busy_i  in  1  accelerator busy flag

Behaviour:
Reset:
- All outputs 0; FSM goes to IDLE; round-robin pointer = 0.
- Reset asserted mid-transfer: at the next edge psel_o/penable_o drop to 0 and the transfer is discarded with no rsp_valid_o.

Eligibility:
- Requester k is eligible if req_valid_i[k] && (!req_write_i[k] || !busy_i).
- Reads are always eligible. Writes stall while busy_i=1.

FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: if any requester is eligible, grant the first eligible index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready_o[grant]=1 combinationally in this cycle.
  - Latch addr/wdata/strb/write/grant index.
  - Pointer <= (grant+1) mod NUM_REQ.
  - Next state SETUP.
- SETUP: psel_o=1, penable_o=0; APB fields driven from latched values.
- ACCESS: psel_o=1, penable_o=1; fields stable. Stay in ACCESS while pready_i=0.
  - On pready_i=1: capture prdata_i (reads) or 0 (writes), and capture pslverr_i. Next state RESP.
- RESP: psel_o=penable_o=0; rsp_valid_o[grant]=1 for one cycle with rsp_rdata_o/rsp_err_o. Next state IDLE.

Timing and ordering:
- Zero-wait latency is 4 cycles from req_ready_o to the IDLE cycle after rsp_valid_o: accept C0, SETUP C1, ACCESS C2, RESP C3.
- Each wait state adds 1 cycle.
- One transfer is outstanding at a time; no back-to-back APB without the RESP/IDLE gap.

Simultaneous events and boundaries:
- busy_i rising after a write has been granted does not abort it.
- busy_i is sampled only in IDLE.
- pslverr_i is ignored unless pready_i=1.
- A requester dropping req_valid_i before acceptance is legal; the request is simply not granted.
- Pointer wrap: after granting NUM_REQ-1, the pointer becomes 0.

APB signal rules:
- APB outputs are registered; paddr_o/pwrite_o/pwdata_o/pstrb_o hold their last values in IDLE/RESP.
- pwdata_o is 0 for reads.

Optional Feature:
MATMUL_ARB_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: psel_o/penable_o drop, go to RESP with rsp_err_o=1, rsp_rdata_o=0.
  - A pready_i arriving in the abort cycle is ignored.
- Undefined: ACCESS waits indefinitely for pready_i; no counter logic is present.

Test Plan:
- Single read from req0, addr 0x10, pready tied 1, prdata 0xDEADBEEF -> req_ready_o[0] at C0; psel=1/penable=0 at C1; penable=1 at C2; rsp_valid_o[0]=1, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0 at C3.
- req0 and req1 both valid continuously with reads, pointer=0 -> grants alternate 0,1,0,1 over 4 transfers; a transfer completes every 4 cycles.
- busy_i=1; req0 write 0x04 data 0x5, req1 read 0x08 -> req1 granted first and req0 stalls; drop busy_i -> req0 write issued with pwdata_o=0x5, pstrb_o=0xF.
- Write with pready low for 3 ACCESS cycles, then pready=1 and pslverr=1 -> ACCESS lasts 4 cycles, penable held; rsp_err_o=1, rsp_rdata_o=0.
- rst_i pulsed during ACCESS -> next edge psel_o=penable_o=0 and no rsp_valid_o; next request is granted from pointer 0.
- With MATMUL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> abort after 16 ACCESS cycles; rsp_err_o=1; the next request proceeds normally.
